// File: rtl/axil_iob_sched.sv
// axil_iob_sched: AXI4-Lite slave to IOb master sequencer.
// Each AXI request channel (AW, W, AR) has a one-entry buffer, so the channels
// stay independent. A single FSM issues one IOb access at a time. Reads and
// writes alternate when both are pending. B and R responses come from registers.
module axil_iob_sched #(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  // AXI4-Lite write address channel
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  // AXI4-Lite write data channel
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  // AXI4-Lite write response channel
  output logic [1:0]               axil_bresp_o,
  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  // AXI4-Lite read address channel
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  // AXI4-Lite read data channel
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,
  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  // IOb master port
  output logic                     iob_avalid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic [DATA_W-1:0]        iob_rdata_i,
  input  logic                     iob_rvalid_i,
  input  logic                     iob_ready_i
);

  localparam int STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_B_RESP  = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_R_RESP  = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

  state_t                  state_q;
  grant_t                  last_grant_q;

  // Channel buffers
  logic                    aw_full_q;
  logic                    w_full_q;
  logic                    ar_full_q;
  logic [AXIL_ADDR_W-1:0]  aw_addr_q;
  logic [AXIL_DATA_W-1:0]  w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [AXIL_ADDR_W-1:0]  ar_addr_q;

  // Registered outputs
  logic                    bvalid_q;
  logic                    rvalid_q;
  logic [AXIL_DATA_W-1:0]  rdata_q;
  logic                    avalid_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W/8-1:0]     wstrb_q;

  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    ar_hs_s;
  logic                    wr_pend_s;
  logic                    rd_pend_s;
  logic                    grant_wr_s;
  logic                    grant_rd_s;

  // A buffer can accept only while it is empty. The readies are also forced
  // low while reset is asserted, so every output reads zero during reset.
  assign axil_awready_o = ~(aw_full_q | arst_i);
  assign axil_wready_o  = ~(w_full_q  | arst_i);
  assign axil_arready_o = ~(ar_full_q | arst_i);

  assign aw_hs_s = axil_awvalid_i & ~aw_full_q;
  assign w_hs_s  = axil_wvalid_i  & ~w_full_q;
  assign ar_hs_s = axil_arvalid_i & ~ar_full_q;

  assign axil_bresp_o  = 2'b00;
  assign axil_rresp_o  = 2'b00;
  assign axil_bvalid_o = bvalid_q;
  assign axil_rvalid_o = rvalid_q;
  assign axil_rdata_o  = rdata_q;
  assign iob_avalid_o  = avalid_q;
  assign iob_addr_o    = addr_q;
  assign iob_wdata_o   = wdata_q;
  assign iob_wstrb_o   = wstrb_q;

  // Arbitration: when both directions are pending, grant the one that was not granted last.
  always_comb begin
    wr_pend_s  = aw_full_q & w_full_q;
    rd_pend_s  = ar_full_q;
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (wr_pend_s && rd_pend_s) begin
      grant_wr_s = (last_grant_q == GRANT_RD);
      grant_rd_s = (last_grant_q == GRANT_WR);
    end else begin
      grant_wr_s = wr_pend_s;
      grant_rd_s = rd_pend_s;
    end
  end

  // Buffer payload capture. A payload is held while its full flag is set.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
    end else begin
      if (aw_hs_s) begin
        aw_addr_q <= axil_awaddr_i;
      end
      if (w_hs_s) begin
        w_data_q <= axil_wdata_i;
        w_strb_q <= axil_wstrb_i;
      end
      if (ar_hs_s) begin
        ar_addr_q <= axil_araddr_i;
      end
    end
  end

  // Sequencing FSM. It owns the buffer full flags, the grant history and every registered output.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_RD;
      aw_full_q    <= 1'b0;
      w_full_q     <= 1'b0;
      ar_full_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      avalid_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      // A capture only happens into an empty buffer, and the FSM only clears
      // a full one, so a set and a clear can never fall in the same cycle.
      if (aw_hs_s) begin
        aw_full_q <= 1'b1;
      end
      if (w_hs_s) begin
        w_full_q <= 1'b1;
      end
      if (ar_hs_s) begin
        ar_full_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_wr_s) begin
            last_grant_q <= GRANT_WR;
            if (w_strb_q != '0) begin
              state_q  <= ST_WR_REQ;
              avalid_q <= 1'b1;
              addr_q   <= aw_addr_q[ADDR_W-1:0];
              wdata_q  <= w_data_q;
              wstrb_q  <= w_strb_q;
            end else begin
              // A write with no byte enabled needs no IOb access; answer it directly.
              state_q   <= ST_B_RESP;
              bvalid_q  <= 1'b1;
              aw_full_q <= 1'b0;
              w_full_q  <= 1'b0;
            end
          end else if (grant_rd_s) begin
            last_grant_q <= GRANT_RD;
            state_q      <= ST_RD_REQ;
            avalid_q     <= 1'b1;
            addr_q       <= ar_addr_q[ADDR_W-1:0];
            wdata_q      <= '0;
            wstrb_q      <= '0;
          end
        end

        ST_WR_REQ: begin
          if (iob_ready_i) begin
            state_q   <= ST_B_RESP;
            avalid_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b1;
          end
        end

        ST_B_RESP: begin
          if (axil_bready_i) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end

        ST_RD_REQ: begin
          if (iob_ready_i) begin
            state_q   <= ST_RD_WAIT;
            avalid_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ar_full_q <= 1'b0;
          end
        end

        ST_RD_WAIT: begin
          if (iob_rvalid_i) begin
            state_q  <= ST_R_RESP;
            rdata_q  <= iob_rdata_i;
            rvalid_q <= 1'b1;
          end
        end

        ST_R_RESP: begin
          if (axil_rready_i) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          bvalid_q <= 1'b0;
          rvalid_q <= 1'b0;
          avalid_q <= 1'b0;
          addr_q   <= '0;
          wdata_q  <= '0;
          wstrb_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_iob_sched.sv
// Testbench for axil_iob_sched. Expected IOb accesses, B responses and R data
// are queued when stimulus is driven. A monitor pops and compares them when the
// DUT produces them.
module tb_axil_iob_sched;

  typedef struct packed {
    logic [20:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } iob_t;

  logic        clk = 1'b0;
  logic        arst;
  logic [20:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [20:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        iob_avalid;
  logic [20:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata;
  logic        iob_rvalid;
  logic        iob_ready;

  int total = 0;
  int bad   = 0;
  int b_seen = 0;
  int r_seen = 0;

  iob_t        exp_iob_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] exp_r_q[$];

  axil_iob_sched dut (
    .clk_i          (clk),
    .arst_i         (arst),
    .axil_awaddr_i  (awaddr),
    .axil_awvalid_i (awvalid),
    .axil_awready_o (awready),
    .axil_wdata_i   (wdata),
    .axil_wstrb_i   (wstrb),
    .axil_wvalid_i  (wvalid),
    .axil_wready_o  (wready),
    .axil_bresp_o   (bresp),
    .axil_bvalid_o  (bvalid),
    .axil_bready_i  (bready),
    .axil_araddr_i  (araddr),
    .axil_arvalid_i (arvalid),
    .axil_arready_o (arready),
    .axil_rdata_o   (rdata),
    .axil_rresp_o   (rresp),
    .axil_rvalid_o  (rvalid),
    .axil_rready_i  (rready),
    .iob_avalid_o   (iob_avalid),
    .iob_addr_o     (iob_addr),
    .iob_wdata_o    (iob_wdata),
    .iob_wstrb_o    (iob_wstrb),
    .iob_rdata_i    (iob_rdata),
    .iob_rvalid_i   (iob_rvalid),
    .iob_ready_i    (iob_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    iob_t got;
    iob_t e;
    got = {iob_addr, iob_wdata, iob_wstrb};
    if (iob_avalid && iob_ready) begin
      total++;
      if (exp_iob_q.size() == 0) begin
        bad++;
        $display("FAIL iob_unexpected: got addr=%h data=%h strb=%h, required no access", iob_addr, iob_wdata, iob_wstrb);
      end else begin
        e = exp_iob_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL iob_access: got addr=%h data=%h strb=%h, required addr=%h data=%h strb=%h",
                   iob_addr, iob_wdata, iob_wstrb, e.addr, e.data, e.strb);
        end
      end
    end
    if (!iob_avalid) begin
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL iob_idle_zero: got addr=%h data=%h strb=%h, required all 0", iob_addr, iob_wdata, iob_wstrb);
      end
    end
    if (bvalid && bready) begin
      total++;
      b_seen++;
      if (exp_b_q.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected: got bresp=%h, required no response", bresp);
      end else if (bresp !== exp_b_q.pop_front()) begin
        bad++;
        $display("FAIL bresp: got %h, required 0", bresp);
      end
    end
    if (rvalid && rready) begin
      logic [31:0] er;
      total++;
      r_seen++;
      if (exp_r_q.size() == 0) begin
        bad++;
        $display("FAIL r_unexpected: got rdata=%h, required no response", rdata);
      end else begin
        er = exp_r_q.pop_front();
        if (rdata !== er || rresp !== 2'b00) begin
          bad++;
          $display("FAIL rdata: got %h resp %h, required %h resp 0", rdata, rresp, er);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    logic [99:0] v;
    v = {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata,
         iob_avalid, iob_addr, iob_wdata, iob_wstrb};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s: got outputs=%h, required all 0", name, v);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #2;
    check_all_zero("reset_outputs");
    tick();
    tick();
    arst = 1'b0;
    tick();
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_readies: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write();
    iob_ready = 1'b1;
    bready    = 1'b0;
    exp_iob_q.push_back({21'h10, 32'hDEADBEEF, 4'hF});
    exp_b_q.push_back(2'b00);
    awaddr = 21'h10; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();                              // cycle N+1
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if (iob_avalid !== 1'b0) begin
      bad++; $display("FAIL wr_avalid_n1: got %b, required 0", iob_avalid);
    end
    tick();                              // cycle N+2
    total++;
    if ({iob_avalid, iob_addr, iob_wstrb} !== {1'b1, 21'h10, 4'hF}) begin
      bad++; $display("FAIL wr_avalid_n2: got avalid=%b addr=%h strb=%h, required 1/10/f", iob_avalid, iob_addr, iob_wstrb);
    end
    tick();                              // cycle N+3
    total++;
    if ({bvalid, bresp, iob_avalid} !== {1'b1, 2'b00, 1'b0}) begin
      bad++; $display("FAIL wr_bvalid_n3: got bvalid=%b bresp=%h avalid=%b, required 1/0/0", bvalid, bresp, iob_avalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    total++;
    if (bvalid !== 1'b0) begin
      bad++; $display("FAIL wr_bvalid_drop: got %b, required 0", bvalid);
    end
  endtask

  task automatic test_read_stall();
    iob_ready = 1'b0;
    rready    = 1'b0;
    exp_iob_q.push_back({21'h24, 32'h0, 4'h0});
    exp_r_q.push_back(32'h12345678);
    araddr = 21'h24; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    total++;
    if (arready !== 1'b0) begin
      bad++; $display("FAIL rd_arready_full: got %b, required 0", arready);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({iob_avalid, iob_addr, iob_wstrb, iob_wdata} !== {1'b1, 21'h24, 4'h0, 32'h0}) begin
        bad++; $display("FAIL rd_avalid_hold%0d: got avalid=%b addr=%h strb=%h, required 1/24/0", i, iob_avalid, iob_addr, iob_wstrb);
      end
      if (i == 3) iob_ready = 1'b1;
      tick();
    end
    iob_ready = 1'b0;
    total++;
    if ({iob_avalid, rvalid} !== 2'b00) begin
      bad++; $display("FAIL rd_wait: got avalid=%b rvalid=%b, required 0/0", iob_avalid, rvalid);
    end
    tick();
    iob_rvalid = 1'b1; iob_rdata = 32'h12345678;
    tick();
    iob_rvalid = 1'b0; iob_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rvalid, rdata} !== {1'b1, 32'h12345678}) begin
        bad++; $display("FAIL rd_rdata_hold%0d: got rvalid=%b rdata=%h, required 1/12345678", i, rvalid, rdata);
      end
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    total++;
    if (rvalid !== 1'b0) begin
      bad++; $display("FAIL rd_rvalid_drop: got %b, required 0", rvalid);
    end
  endtask

  task automatic test_aw_before_w();
    iob_ready = 1'b1;
    exp_iob_q.push_back({21'h40, 32'hA5A50001, 4'h3});
    exp_b_q.push_back(2'b00);
    awaddr = 21'h40; awvalid = 1'b1;
    tick();                              // N+1
    awvalid = 1'b0;
    total++;
    if ({awready, iob_avalid} !== 2'b00) begin
      bad++; $display("FAIL awfirst_n1: got awready=%b avalid=%b, required 0/0", awready, iob_avalid);
    end
    tick();                              // N+2
    tick();                              // N+3: W handshake cycle
    wdata = 32'hA5A50001; wstrb = 4'h3; wvalid = 1'b1;
    total++;
    if (iob_avalid !== 1'b0) begin
      bad++; $display("FAIL awfirst_noissue: got %b, required 0", iob_avalid);
    end
    tick();                              // W+1
    wvalid = 1'b0;
    total++;
    if (iob_avalid !== 1'b0) begin
      bad++; $display("FAIL awfirst_w1: got %b, required 0", iob_avalid);
    end
    tick();                              // W+2
    total++;
    if ({iob_avalid, iob_addr, iob_wstrb} !== {1'b1, 21'h40, 4'h3}) begin
      bad++; $display("FAIL awfirst_w2: got avalid=%b addr=%h strb=%h, required 1/40/3", iob_avalid, iob_addr, iob_wstrb);
    end
    tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_zero_strobe();
    iob_ready = 1'b1;
    exp_b_q.push_back(2'b00);
    awaddr = 21'h80; awvalid = 1'b1;
    wdata = 32'h55; wstrb = 4'h0; wvalid = 1'b1;
    tick();                              // N+1
    awvalid = 1'b0; wvalid = 1'b0;
    total++;
    if ({iob_avalid, bvalid} !== 2'b00) begin
      bad++; $display("FAIL zs_n1: got avalid=%b bvalid=%b, required 0/0", iob_avalid, bvalid);
    end
    tick();                              // N+2
    total++;
    if ({iob_avalid, bvalid} !== 2'b01) begin
      bad++; $display("FAIL zs_n2: got avalid=%b bvalid=%b, required 0/1", iob_avalid, bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    total++;
    if ({awready, wready} !== 2'b11) begin
      bad++; $display("FAIL zs_buffers_free: got %b, required 11", {awready, wready});
    end
  endtask

  task automatic test_arbitration();
    logic [20:0] wa [2];
    logic [31:0] wd [2];
    logic [20:0] ra [2];
    int aw_i, w_i, ar_i, rd_idx;
    logic aw_fire, w_fire, ar_fire, rd_acc, rv_next;
    bit done;
    wa = '{21'h100, 21'h104};
    wd = '{32'h11110000, 32'h22220000};
    ra = '{21'h200, 21'h204};
    arst = 1'b1;
    tick();
    arst = 1'b0;
    tick();
    b_seen = 0; r_seen = 0;
    exp_iob_q.push_back({wa[0], wd[0], 4'hF});
    exp_iob_q.push_back({ra[0], 32'h0, 4'h0});
    exp_iob_q.push_back({wa[1], wd[1], 4'hF});
    exp_iob_q.push_back({ra[1], 32'h0, 4'h0});
    exp_b_q.push_back(2'b00);
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back(32'hC0DE0000);
    exp_r_q.push_back(32'hC0DE0001);
    iob_ready = 1'b1; bready = 1'b1; rready = 1'b1;
    aw_i = 0; w_i = 0; ar_i = 0; rd_idx = 0; rv_next = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      awvalid = (aw_i < 2); awaddr = (aw_i < 2) ? wa[aw_i] : 21'h0;
      wvalid  = (w_i < 2);  wdata  = (w_i < 2) ? wd[w_i] : 32'h0; wstrb = 4'hF;
      arvalid = (ar_i < 2); araddr = (ar_i < 2) ? ra[ar_i] : 21'h0;
      iob_rvalid = rv_next;
      iob_rdata  = rv_next ? (32'hC0DE0000 | 32'(rd_idx)) : 32'h0;
      aw_fire = awvalid & awready;
      w_fire  = wvalid & wready;
      ar_fire = arvalid & arready;
      rd_acc  = iob_avalid & iob_ready & (iob_wstrb == 4'h0);
      tick();
      if (aw_fire) aw_i++;
      if (w_fire) w_i++;
      if (ar_fire) ar_i++;
      if (rv_next) rd_idx++;
      rv_next = rd_acc;
      if (b_seen >= 2 && r_seen >= 2) begin
        done = 1'b1;
        break;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; iob_rvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL arb_timeout: got b=%0d r=%0d responses, required 2/2", b_seen, r_seen);
    end
  endtask

  task automatic test_reset_mid();
    iob_ready = 1'b1;
    rready    = 1'b1;
    exp_iob_q.push_back({21'h30, 32'h0, 4'h0});
    araddr = 21'h30; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    tick();                              // RD_REQ, accepted at next edge
    tick();                              // RD_WAIT
    arst = 1'b1;
    #1;
    check_all_zero("midreset_outputs");
    tick();
    arst = 1'b0;
    iob_rvalid = 1'b1; iob_rdata = 32'h99;
    tick();
    iob_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rvalid !== 1'b0) begin
        bad++; $display("FAIL midreset_rvalid%0d: got %b, required 0", i, rvalid);
      end
      tick();
    end
    rready = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    iob_rdata = '0; iob_rvalid = 1'b0; iob_ready = 1'b0;
    test_reset();
    test_write();
    test_read_stall();
    test_aw_before_w();
    test_zero_strobe();
    test_arbitration();
    test_reset_mid();
    tick();
    total++;
    if (exp_iob_q.size() != 0 || exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got pending iob=%0d b=%0d r=%0d, required 0/0/0",
               exp_iob_q.size(), exp_b_q.size(), exp_r_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_iob_sched.md
Name:
axil_iob_sched

Overview:
Sequencing controller that converts an AXI4-Lite slave port into a single IOb master port with full AXI handshakes. Independent one-entry AW/W/AR buffers decouple the AXI channels. A round-robin FSM issues exactly one IOb access at a time and generates registered B/R responses. It sits between an AXI-Lite interconnect and IOb peripherals, replacing pass-through bridging wherever correct AXI back-pressure and response sequencing are required.

Parameters:
AXIL_ADDR_W  21  AXI-Lite address width
AXIL_DATA_W  32  AXI-Lite data width; multiple of 8
ADDR_W  AXIL_ADDR_W  IOb address width; ADDR_W<=AXIL_ADDR_W; iob_addr_o = buffered addr[ADDR_W-1:0]
DATA_W  AXIL_DATA_W  IOb data width; must equal AXIL_DATA_W

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
axil_awaddr_i  in  AXIL_ADDR_W  write address
axil_awvalid_i  in  1  write address valid
axil_awready_o  out  1  write address ready
axil_wdata_i  in  AXIL_DATA_W  write data
axil_wstrb_i  in  AXIL_DATA_W/8  write strobes
axil_wvalid_i  in  1  write data valid
axil_wready_o  out  1  write data ready
axil_bresp_o  out  2  write response, always 2'b00
axil_bvalid_o  out  1  write response valid
axil_bready_i  in  1  write response ready
axil_araddr_i  in  AXIL_ADDR_W  read address
axil_arvalid_i  in  1  read address valid
axil_arready_o  out  1  read address ready
axil_rdata_o  out  AXIL_DATA_W  read data, registered
axil_rresp_o  out  2  read response, always 2'b00
axil_rvalid_o  out  1  read data valid
axil_rready_i  in  1  read data ready
iob_avalid_o  out  1  IOb request valid
iob_addr_o  out  ADDR_W  IOb address
iob_wdata_o  out  DATA_W  IOb write data
iob_wstrb_o  out  DATA_W/8  IOb strobes; nonzero=write, zero=read
iob_rdata_i  in  DATA_W  IOb read data
iob_rvalid_i  in  1  IOb read data valid
iob_ready_i  in  1  IOb request accepted when high with avalid

Behaviour:
- Reset (arst_i high, async): state IDLE; aw_full/w_full/ar_full=0; last_grant=read, so the first contested grant goes to write; all outputs 0, including rdata_o.
- Buffers: awready_o=~aw_full, wready_o=~w_full, arready_o=~ar_full. Capture on valid&ready. AW and W may arrive in any order or cycle.
- wr_pend=aw_full&w_full; rd_pend=ar_full. In IDLE:
  - both pending: grant the opposite of last_grant;
  - else grant whichever is pending.
  - last_grant updates on each grant.
- FSM states: IDLE, WR_REQ, B_RESP, RD_REQ, RD_WAIT, R_RESP.
  - IDLE->WR_REQ on a write grant whose buffered wstrb!=0.
  - IDLE->B_RESP on a write grant whose wstrb==0: no IOb access; aw_full/w_full cleared.
  - IDLE->RD_REQ on a read grant.
- WR_REQ: iob_avalid_o=1, addr/wdata/wstrb driven from buffers. Held stable until iob_ready_i. On ready: clear aw_full/w_full, go to B_RESP.
- B_RESP: bvalid_o=1 until bready_i, then IDLE. New AW/W may be captured during B_RESP.
- RD_REQ: avalid=1, addr from AR buffer, wstrb=0, wdata=0. On ready: clear ar_full, go to RD_WAIT.
- RD_WAIT: on iob_rvalid_i, register iob_rdata_i into rdata_o and go to R_RESP. iob_rvalid_i is ignored in every other state.
- R_RESP: rvalid_o=1, rdata_o stable until rready_i, then IDLE.
- iob_addr_o, iob_wdata_o and iob_wstrb_o are 0 whenever iob_avalid_o=0. At most one IOb transaction is outstanding.
- Latency (handshake in cycle N; ready_i=1; rvalid_i one cycle after acceptance):
  - write: avalid N+2, bvalid N+3;
  - zero-strobe write: bvalid N+2;
  - read: avalid N+2, rvalid_o N+4.
- Reset mid-operation clears everything immediately. A late iob_rvalid_i after reset produces no response.

Test Plan:
- AW 0x10 + W 0xDEADBEEF/strb 0xF in cycle N, ready_i=1 -> avalid N+2 with addr 0x10, wstrb 0xF; bvalid N+3, bresp 0.
- AR 0x24; ready_i low 3 cycles; rvalid_i 2 cycles after acceptance with data 0x12345678; rready low 5 cycles -> avalid held 4 cycles with stable addr; rdata_o=0x12345678 held until rready.
- AW 3 cycles before W -> no avalid until W captured, awready low after AW capture, write issued at W-cycle+2.
- AW/W and AR continuously pending, 4 transactions -> IOb order W,R,W,R.
- Write with wstrb=0 -> iob_avalid_o never asserts; bvalid at N+2.
- arst_i pulsed in RD_WAIT, then iob_rvalid_i -> all outputs 0 immediately; axil_rvalid_o never asserts.
